key_detect: RTL and testbench

- Debounces the two board push-buttons and emits one clean single-cycle pulse per accepted press on each key.
- Sits between the raw key pins and the display/LED consumers (nixie-tube driver, red LED driver), which share `Key_Out`.
- Fully synchronous to the 50 MHz system clock.

---
 rtl/key_detect_pkg.sv | 26 ++
 rtl/key_debounce_ch.sv | 188 ++++++++++++++++++
 rtl/key_detect.sv | 47 ++++
 tb/tb_key_detect.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_detect_pkg.sv
// -----------------------------------------------------------------------------
// key_detect_pkg
//   Shared constants and helpers for the push-button debounce block.
//
//   Contents:
//     NUM_KEYS        number of independent key channels
//     LEVEL_RELEASED  normalised key level when the button is up
//     LEVEL_PRESSED   normalised key level when the button is down
//     ms_to_cycles()  converts a millisecond interval to clock cycles
//
//   Optional feature macro used by the importing files: KEY_REPEAT_EN
// -----------------------------------------------------------------------------
package key_detect_pkg;

    localparam int NUM_KEYS = 2;

    // Levels after active-low/active-high normalisation: 1 always means "down".
    localparam logic LEVEL_RELEASED = 1'b0;
    localparam logic LEVEL_PRESSED  = 1'b1;

    // Divide first so a 50 MHz clock with a few hundred ms still fits in 32 bits.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage : key_detect_pkg

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
//   One push-button channel: two-flop synchroniser, level debounce, and a
//   registered single-cycle pulse on every accepted press.
//
//   Ports:
//     Sys_CLK    in   system clock, rising edge
//     Sys_RST    in   asynchronous active-high reset
//     key_pin    in   raw asynchronous key pin
//     key_pulse  out  registered pulse, one cycle per accepted press
//
//   Optional feature (macro KEY_REPEAT_EN): while the debounced key stays
//   down, extra pulses fire REPEAT_DELAY_MS after the press pulse and then
//   every REPEAT_RATE_MS. Without the macro the repeat logic is absent.
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_detect_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 50000000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic Sys_CLK,
    input  logic Sys_RST,
    input  logic key_pin,
    output logic key_pulse
);

    localparam int DEBOUNCE_CYCLES = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
    // Width guard keeps the declarations legal long enough for the check below
    // to report a bad configuration instead of a zero-width vector error.
    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Raw pin level while the button is up; synchroniser resets to this so a
    // reset never looks like a press by itself.
    localparam logic PIN_RELEASED = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_debounce_ch: DEBOUNCE_CYCLES must be at least 1");
    end

    if (REPEAT_DELAY_MS < 0 || REPEAT_RATE_MS < 0) begin : g_bad_repeat_param
        $error("key_debounce_ch: repeat intervals must not be negative");
    end

    // -------------------------------------------------------------------------
    // Two-flop synchroniser on the raw pin
    // -------------------------------------------------------------------------
    logic sync1_reg;
    logic sync2_reg;

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            sync1_reg <= PIN_RELEASED;
            sync2_reg <= PIN_RELEASED;
        end else begin
            sync1_reg <= key_pin;
            sync2_reg <= sync1_reg;
        end
    end

    logic pressed;
    assign pressed = (KEY_ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;

    // -------------------------------------------------------------------------
    // Debounce: the level must disagree with the accepted state for
    // DEBOUNCE_CYCLES consecutive cycles before it is taken over. Any cycle of
    // agreement restarts the count, so the counter can never wrap.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             state_reg;
    logic             state_next;

    always_comb begin
        cnt_next   = cnt_reg;
        state_next = state_reg;
        if (pressed == state_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            state_next = pressed;
            cnt_next   = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            cnt_reg   <= '0;
            state_reg <= LEVEL_RELEASED;
        end else begin
            cnt_reg   <= cnt_next;
            state_reg <= state_next;
        end
    end

    // Previous debounced state, used to find the released->pressed edge.
    logic state_prev_reg;

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            state_prev_reg <= LEVEL_RELEASED;
        end else begin
            state_prev_reg <= state_reg;
        end
    end

    logic press_edge;
    assign press_edge = (state_reg == LEVEL_PRESSED) && (state_prev_reg == LEVEL_RELEASED);

    // -------------------------------------------------------------------------
    // Auto-repeat
    // -------------------------------------------------------------------------
    logic repeat_fire;

`ifdef KEY_REPEAT_EN
    localparam int REPEAT_DELAY_CYCLES = ms_to_cycles(CLK_FREQ_HZ, REPEAT_DELAY_MS);
    localparam int REPEAT_RATE_CYCLES  = ms_to_cycles(CLK_FREQ_HZ, REPEAT_RATE_MS);
    localparam int HOLD_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                              REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int HOLD_W   = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE_CYCLES - 1);

    if (REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_repeat
        $error("key_debounce_ch: repeat intervals must be at least 1 cycle");
    end

    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [HOLD_W-1:0] hold_cnt_next;
    // Set once the first (longer) delay has elapsed; later intervals use the rate.
    logic              in_rate_reg;
    logic              in_rate_next;
    logic              held;

    // Counting starts the cycle after the press pulse, so the first repeat
    // lands exactly REPEAT_DELAY_CYCLES after it.
    assign held = (state_reg == LEVEL_PRESSED) && (state_prev_reg == LEVEL_PRESSED);

    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        in_rate_next  = in_rate_reg;
        repeat_fire   = 1'b0;
        if (!held) begin
            hold_cnt_next = '0;
            in_rate_next  = 1'b0;
        end else if (hold_cnt_reg == (in_rate_reg ? RATE_LAST : DELAY_LAST)) begin
            repeat_fire   = 1'b1;
            hold_cnt_next = '0;
            in_rate_next  = 1'b1;
        end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            hold_cnt_reg <= '0;
            in_rate_reg  <= 1'b0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
            in_rate_reg  <= in_rate_next;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Registered output pulse
    // -------------------------------------------------------------------------
    logic pulse_reg;

    always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
        if (Sys_RST) begin
            pulse_reg <= 1'b0;
        end else begin
            pulse_reg <= press_edge | repeat_fire;
        end
    end

    assign key_pulse = pulse_reg;

endmodule : key_debounce_ch

// File: rtl/key_detect.sv
// -----------------------------------------------------------------------------
// key_detect
//   Debounces the board push-buttons and emits one clean single-cycle pulse
//   per accepted press on each key. Channels are fully independent.
//
//   Ports:
//     Sys_CLK  in   [1]         system clock, rising edge
//     Sys_RST  in   [1]         asynchronous active-high reset
//     Key_In   in   [NUM_KEYS]  raw asynchronous key pins, bit i = key i
//     Key_Out  out  [NUM_KEYS]  registered press pulses, bit i = key i
//
//   Latency: a pin change first sampled at edge t shows as a pulse after
//   edge t+2+DEBOUNCE_CYCLES.
//
//   Optional feature macro: KEY_REPEAT_EN (hold-to-repeat pulses).
// -----------------------------------------------------------------------------
module key_detect
    import key_detect_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 50000000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic                Sys_CLK,
    input  logic                Sys_RST,
    input  logic [NUM_KEYS-1:0] Key_In,
    output logic [NUM_KEYS-1:0] Key_Out
);

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_debounce_ch #(
            .CLK_FREQ_HZ     (CLK_FREQ_HZ),
            .DEBOUNCE_MS     (DEBOUNCE_MS),
            .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS)
        ) u_ch (
            .Sys_CLK   (Sys_CLK),
            .Sys_RST   (Sys_RST),
            .key_pin   (Key_In[gi]),
            .key_pulse (Key_Out[gi])
        );
    end

endmodule : key_detect

// File: tb/tb_key_detect.sv
// -----------------------------------------------------------------------------
// tb_key_detect
//   Self-checking bench for key_detect with CLK_FREQ_HZ=1000, DEBOUNCE_MS=4
//   (4 debounce cycles), active-low keys. A reference model predicts every
//   Key_Out cycle from the sampled pin history: a level is accepted once the
//   last four synchronised samples all disagree with the accepted level, and
//   pulses follow from the acceptance time. Define KEY_REPEAT_EN for the
//   auto-repeat build (delay 10, rate 5 cycles).
// -----------------------------------------------------------------------------
module tb_key_detect;

    localparam int CLK_HZ  = 1000;
    localparam int DEB_MS  = 4;
    localparam int DEB_CYC = 4;
    localparam int DLY_CYC = 10;
    localparam int RATE_CYC = 5;

    logic       Sys_CLK = 1'b0;
    logic       Sys_RST;
    logic [1:0] Key_In;
    logic [1:0] Key_Out;

    key_detect #(
        .CLK_FREQ_HZ     (CLK_HZ),
        .DEBOUNCE_MS     (DEB_MS),
        .KEY_ACTIVE_LOW  (1),
        .REPEAT_DELAY_MS (DLY_CYC),
        .REPEAT_RATE_MS  (RATE_CYC)
    ) dut (
        .Sys_CLK (Sys_CLK),
        .Sys_RST (Sys_RST),
        .Key_In  (Key_In),
        .Key_Out (Key_Out)
    );

    always #5 Sys_CLK = ~Sys_CLK;

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_cnt     = 0;

    // Reference model state
    logic sh [2][8];       // normalised pressed samples, [0] = newest
    logic ds [2];          // accepted (debounced) level per key
    int   rise_edge [2];   // edge at which the key was accepted as pressed, -1 if up

    // Observation bookkeeping
    int pulse_cnt [2];
    int first_pulse [2];
    int pulse_edges [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 8; j++) sh[k][j] = 1'b0;
            ds[k]        = 1'b0;
            rise_edge[k] = -1;
        end
    endtask

    task automatic clear_marks();
        for (int k = 0; k < 2; k++) begin
            pulse_cnt[k]   = 0;
            first_pulse[k] = -1000;
        end
        for (int j = 0; j < 8; j++) pulse_edges[j] = -1;
    endtask

    // One clock edge: advance the model, then compare Key_Out just after the edge.
    task automatic tick();
        logic [1:0] exp;
        logic       all_diff;
        int         age;
        @(posedge Sys_CLK);
        edge_cnt++;
        exp = 2'b00;
        if (Sys_RST) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                // Pulses visible after this edge depend on acceptance up to the previous edge.
                if (rise_edge[k] >= 0) begin
                    age = edge_cnt - rise_edge[k] - 1;
                    if (age == 0) exp[k] = 1'b1;
`ifdef KEY_REPEAT_EN
                    else if (age >= DLY_CYC && ((age - DLY_CYC) % RATE_CYC) == 0) exp[k] = 1'b1;
`endif
                end
                for (int j = 7; j > 0; j--) sh[k][j] = sh[k][j-1];
                sh[k][0] = ~Key_In[k];
                // Samples seen by the debouncer at this edge are two edges old.
                all_diff = 1'b1;
                for (int j = 2; j < 2 + DEB_CYC; j++) begin
                    if (sh[k][j] == ds[k]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    ds[k]        = ~ds[k];
                    rise_edge[k] = ds[k] ? edge_cnt : -1;
                end
            end
        end
        #1;
        check_eq("key_out", {30'd0, Key_Out}, {30'd0, exp});
        for (int k = 0; k < 2; k++) begin
            if (Key_Out[k] === 1'b1) begin
                if (pulse_cnt[k] == 0) first_pulse[k] = edge_cnt;
                if (k == 0 && pulse_cnt[0] < 8) pulse_edges[pulse_cnt[0]] = edge_cnt;
                pulse_cnt[k]++;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int seen;
        int run_left [2];
        int exp_cnt;

        model_reset();
        clear_marks();

        // ---- reset with keys idle ----
        Sys_RST = 1'b1;
        Key_In  = 2'b11;
        #1;
        check_eq("rst_out_during", {30'd0, Key_Out}, 32'd0);
        ticks(3);
        Sys_RST = 1'b0;
        clear_marks();
        ticks(50);
        check_eq("idle_no_pulse", pulse_cnt[0] + pulse_cnt[1], 0);
        $display("[TB] idle after reset: pulses k0=%0d k1=%0d", pulse_cnt[0], pulse_cnt[1]);

        // ---- key 0 press held 20 cycles ----
        clear_marks();
        Key_In = 2'b10;
        t = edge_cnt + 1;
        ticks(20);
        Key_In = 2'b11;
        ticks(12);
        check_eq("k0_latency", first_pulse[0] - t, 6);
`ifdef KEY_REPEAT_EN
        exp_cnt = 3;
`else
        exp_cnt = 1;
`endif
        check_eq("k0_pulse_count", pulse_cnt[0], exp_cnt);
        check_eq("k0_no_k1", pulse_cnt[1], 0);
        $display("[TB] key0 hold 20: pulses=%0d first at +%0d", pulse_cnt[0], first_pulse[0] - t);

        // ---- key 1 bounce then real press ----
        clear_marks();
        Key_In = 2'b01;
        ticks(3);
        Key_In = 2'b11;
        ticks(10);
        check_eq("k1_bounce_ignored", pulse_cnt[1], 0);
        Key_In = 2'b01;
        t = edge_cnt + 1;
        ticks(10);
        Key_In = 2'b11;
        ticks(12);
        check_eq("k1_pulse_count", pulse_cnt[1], 1);
        check_eq("k1_latency", first_pulse[1] - t, 6);
        $display("[TB] key1 bounce+press: pulses=%0d", pulse_cnt[1]);

        // ---- both keys on the same edge ----
        clear_marks();
        Key_In = 2'b00;
        t = edge_cnt + 1;
        ticks(10);
        Key_In = 2'b11;
        ticks(12);
        check_eq("both_k0_count", pulse_cnt[0], 1);
        check_eq("both_k1_count", pulse_cnt[1], 1);
        check_eq("both_k0_latency", first_pulse[0] - t, 6);
        check_eq("both_k1_latency", first_pulse[1] - t, 6);
        $display("[TB] both keys: pulses k0=%0d k1=%0d", pulse_cnt[0], pulse_cnt[1]);

        // ---- async reset kills a live pulse ----
        clear_marks();
        Key_In = 2'b10;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            tick();
            if (Key_Out[0] === 1'b1) seen = 1;
        end
        check_eq("pulse_before_rst", seen, 1);
        Sys_RST = 1'b1;
        #1;
        check_eq("rst_async_clear", {30'd0, Key_Out}, 32'd0);
        ticks(2);
        Sys_RST = 1'b0;
        Key_In  = 2'b11;
        ticks(12);
        $display("[TB] async reset on live pulse: seen=%0d", seen);

        // ---- reset mid-debounce, key held through release ----
        Key_In = 2'b10;
        ticks(2);
        Sys_RST = 1'b1;
        #1;
        check_eq("rst_mid_debounce", {30'd0, Key_Out}, 32'd0);
        ticks(2);
        Sys_RST = 1'b0;
        clear_marks();
        t = edge_cnt + 1;
        ticks(8);
        Key_In = 2'b11;
        ticks(12);
        check_eq("post_rst_latency", first_pulse[0] - t, 6);
        check_eq("post_rst_count", pulse_cnt[0], 1);
        $display("[TB] held through reset: pulses=%0d first at +%0d", pulse_cnt[0], first_pulse[0] - t);

        // ---- key 0 held 30 cycles (repeat scenario) ----
        clear_marks();
        Key_In = 2'b10;
        t = edge_cnt + 1;
        ticks(30);
        Key_In = 2'b11;
        ticks(12);
`ifdef KEY_REPEAT_EN
        check_eq("rep_count", pulse_cnt[0], 5);
        check_eq("rep_p0", pulse_edges[0] - t, 6);
        check_eq("rep_p1", pulse_edges[1] - t, 16);
        check_eq("rep_p2", pulse_edges[2] - t, 21);
        check_eq("rep_p3", pulse_edges[3] - t, 26);
        check_eq("rep_p4", pulse_edges[4] - t, 31);
`else
        check_eq("hold30_count", pulse_cnt[0], 1);
        check_eq("hold30_latency", pulse_edges[0] - t, 6);
`endif
        $display("[TB] key0 hold 30: pulses=%0d", pulse_cnt[0]);

        // ---- randomized bouncing on both keys, occasional resets ----
        clear_marks();
        run_left[0] = 0;
        run_left[1] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (run_left[k] == 0) begin
                    Key_In[k]   = 1'($urandom_range(0, 1));
                    run_left[k] = $urandom_range(1, 9);
                end
                run_left[k]--;
            end
            if ($urandom_range(0, 299) == 0) begin
                Sys_RST = 1'b1;
                #1;
                check_eq("rand_rst_async", {30'd0, Key_Out}, 32'd0);
                ticks(2);
                Sys_RST = 1'b0;
            end
            tick();
        end
        $display("[TB] random phase: pulses k0=%0d k1=%0d", pulse_cnt[0], pulse_cnt[1]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_key_detect
